// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared BTB state encoding, defaults and counter constants
package branch_target_buffer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } btb_state_e;

  localparam int BTB_ENTRIES_DEF   = 64;
  localparam int BTB_TAG_WIDTH_DEF = 8;
  localparam int BTB_CNT_WIDTH_DEF = 2;

  // Counter seed on allocation: weakly taken.
  function automatic int cnt_weak_taken(input int w);
    return 1 << (w - 1);
  endfunction

  // Counter seed on clear: weakly not-taken.
  function automatic int cnt_weak_not_taken(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - combinational saturating up/down counter step with load
module bp_sat_counter #(
  parameter int CNT_WIDTH = 2
) (
  input  logic [CNT_WIDTH-1:0] cnt_in,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic [CNT_WIDTH-1:0] cnt_out
);

  always_comb begin
    cnt_out = cnt_in;
    if (load) begin
      cnt_out = load_val;
    end else if (inc && (cnt_in != {CNT_WIDTH{1'b1}})) begin
      cnt_out = cnt_in + CNT_WIDTH'(1);
    end else if (dec && (cnt_in != '0)) begin
      cnt_out = cnt_in - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with 2-state clear sweep and mispredict counter
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES   = BTB_ENTRIES_DEF,
  parameter int TAG_WIDTH = BTB_TAG_WIDTH_DEF,
  parameter int CNT_WIDTH = BTB_CNT_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_pc,
  output logic        o_hit,
  output logic        o_predict_taken,
  output logic [31:0] o_target,
  input  logic        i_update_valid,
  input  logic [31:0] i_update_pc,
  input  logic        i_update_taken,
  input  logic [31:0] i_update_target,
  input  logic        i_update_mispredict,
  input  logic        i_invalidate,
  output logic        o_busy,
  output logic [15:0] o_mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_WIDTH-1:0] CNT_WT  = CNT_WIDTH'(cnt_weak_taken(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] CNT_WNT = CNT_WIDTH'(cnt_weak_not_taken(CNT_WIDTH));
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(ENTRIES - 1);

  logic                 valid_q  [ENTRIES];
  logic                 valid_d  [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_d    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];
  logic [31:0]          target_d [ENTRIES];
  logic [CNT_WIDTH-1:0] cnt_q    [ENTRIES];
  logic [CNT_WIDTH-1:0] cnt_d    [ENTRIES];

  btb_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic           busy_q, busy_d;
  logic [15:0]    mp_cnt_q, mp_cnt_d;

  logic [IDX_W-1:0]     lk_idx, up_idx;
  logic [TAG_WIDTH-1:0] lk_tag, up_tag;
  logic                 lk_hit, up_hit;
  logic [CNT_WIDTH-1:0] up_cnt_next;
  logic                 unused_pc_bits;

  assign lk_idx = i_pc[IDX_W+1:2];
  assign lk_tag = i_pc[IDX_W+2 +: TAG_WIDTH];
  assign up_idx = i_update_pc[IDX_W+1:2];
  assign up_tag = i_update_pc[IDX_W+2 +: TAG_WIDTH];
  assign unused_pc_bits = ^{i_pc, i_update_pc};

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign lk_hit          = (state_q == ST_IDLE) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign o_hit           = lk_hit;
  assign o_predict_taken = lk_hit && cnt_q[lk_idx][CNT_WIDTH-1];
  assign o_target        = lk_hit ? target_q[lk_idx] : 32'h0;
  assign o_busy          = busy_q;
  assign o_mispredict_cnt = mp_cnt_q;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  bp_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_entry_cnt (
    .cnt_in   (cnt_q[up_idx]),
    .inc      (i_update_taken),
    .dec      (!i_update_taken),
    .load     (!up_hit),
    .load_val (CNT_WT),
    .cnt_out  (up_cnt_next)
  );

  bp_sat_counter #(.CNT_WIDTH(16)) u_mp_cnt (
    .cnt_in   (mp_cnt_q),
    .inc      (i_update_valid && i_update_mispredict),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val (16'h0),
    .cnt_out  (mp_cnt_d)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_invalidate) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
          busy_d  = 1'b1;
        end else if (i_update_valid && (up_hit || i_update_taken)) begin
          valid_d[up_idx] = 1'b1;
          tag_d[up_idx]   = up_tag;
          cnt_d[up_idx]   = up_cnt_next;
          if (i_update_taken) target_d[up_idx] = i_update_target;
        end
      end
      ST_CLEAR: begin
        valid_d[idx_q] = 1'b0;
        cnt_d[idx_q]   = CNT_WNT;
        if (i_invalidate) begin
          idx_d = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      mp_cnt_q <= 16'h0;
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      mp_cnt_q <= mp_cnt_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage carries no reset; valid bits alone gate its use.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    cnt_q    <= cnt_d;
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed table-driven bench for branch_target_buffer
module tb_branch_target_buffer;

  localparam logic [31:0] PC_A  = 32'h0040_0010;
  localparam logic [31:0] PC_B  = 32'h0041_0010;
  localparam logic [31:0] PC_C  = 32'h0040_0024;
  localparam logic [31:0] PC_B3 = 32'h0041_0013;
  localparam logic [31:0] PC_D  = 32'h0040_00F0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_pc;
  logic        o_hit, o_predict_taken, o_busy;
  logic [31:0] o_target;
  logic        i_update_valid, i_update_taken, i_update_mispredict, i_invalidate;
  logic [31:0] i_update_pc, i_update_target;
  logic [15:0] o_mispredict_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(.ENTRIES(64), .TAG_WIDTH(16), .CNT_WIDTH(2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_pc                (i_pc),
    .o_hit               (o_hit),
    .o_predict_taken     (o_predict_taken),
    .o_target            (o_target),
    .i_update_valid      (i_update_valid),
    .i_update_pc         (i_update_pc),
    .i_update_taken      (i_update_taken),
    .i_update_target     (i_update_target),
    .i_update_mispredict (i_update_mispredict),
    .i_invalidate        (i_invalidate),
    .o_busy              (o_busy),
    .o_mispredict_cnt    (o_mispredict_cnt)
  );

  typedef struct {
    logic        up_v;
    logic [31:0] up_pc;
    logic        up_tk;
    logic [31:0] up_tgt;
    logic        up_mp;
    logic [31:0] lk_pc;
    logic        e_hit;
    logic        e_pt;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic tk, logic [31:0] tgt, logic mp,
                              logic [31:0] lk, logic h, logic pt, logic [31:0] et);
    vec_t r;
    r.up_v = v; r.up_pc = pc; r.up_tk = tk; r.up_tgt = tgt; r.up_mp = mp;
    r.lk_pc = lk; r.e_hit = h; r.e_pt = pt; r.e_tgt = et;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_update_valid = 1'b0; i_update_pc = 32'h0; i_update_taken = 1'b0;
    i_update_target = 32'h0; i_update_mispredict = 1'b0; i_invalidate = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    i_update_valid = 1'b1; i_update_pc = pc; i_update_taken = tk; i_update_target = tgt;
    tick();
    i_update_valid = 1'b0;
  endtask

  task automatic lookup_chk(input string name, input logic [31:0] pc, input logic h,
                            input logic pt, input logic [31:0] tgt);
    i_pc = pc;
    #1;
    chk({name, " hit"}, {31'b0, o_hit}, {31'b0, h});
    chk({name, " pred"}, {31'b0, o_predict_taken}, {31'b0, pt});
    chk({name, " tgt"}, o_target, tgt);
  endtask

  // One invalidate; optionally re-invalidate at busy cycle restart_at and poke an update.
  task automatic sweep(input int restart_at, input logic poke, output int busy_cycles, output int leaks);
    i_invalidate = 1'b1;
    i_update_valid = poke; i_update_pc = PC_C; i_update_taken = 1'b1; i_update_target = 32'h500;
    tick();
    i_invalidate = 1'b0; i_update_valid = 1'b0;
    busy_cycles = 0; leaks = 0;
    for (int g = 0; g < 300 && o_busy; g++) begin
      busy_cycles++;
      i_invalidate = (busy_cycles == restart_at);
      i_update_valid = poke && (busy_cycles == 20);
      i_pc = PC_B;
      #1;
      if (o_hit || o_predict_taken || o_target != 32'h0) leaks++;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    int mp_model;
    int busy_cycles, leaks;

    vecs[0]  = mk(0, 32'h0, 0, 32'h0,         0, PC_A,  0, 0, 32'h0);
    vecs[1]  = mk(1, PC_A,  1, 32'h0040_0100, 0, PC_A,  0, 0, 32'h0);
    vecs[2]  = mk(1, PC_A,  0, 32'h0,         1, PC_A,  1, 1, 32'h0040_0100);
    vecs[3]  = mk(1, PC_A,  0, 32'h0,         1, PC_A,  1, 0, 32'h0040_0100);
    vecs[4]  = mk(1, PC_A,  0, 32'h0,         0, PC_A,  1, 0, 32'h0040_0100);
    vecs[5]  = mk(1, PC_A,  1, 32'h0040_0200, 0, PC_A,  1, 0, 32'h0040_0100);
    vecs[6]  = mk(1, PC_A,  1, 32'h0040_0300, 0, PC_A,  1, 0, 32'h0040_0200);
    vecs[7]  = mk(1, PC_A,  1, 32'h0040_0300, 0, PC_A,  1, 1, 32'h0040_0300);
    vecs[8]  = mk(1, PC_A,  1, 32'h0040_0300, 0, PC_A,  1, 1, 32'h0040_0300);
    vecs[9]  = mk(1, PC_A,  0, 32'h1111_1110, 0, PC_A,  1, 1, 32'h0040_0300);
    vecs[10] = mk(1, PC_A,  0, 32'h0,         0, PC_A,  1, 1, 32'h0040_0300);
    vecs[11] = mk(0, PC_A,  1, 32'h2222_2220, 1, PC_A,  1, 0, 32'h0040_0300);
    vecs[12] = mk(1, PC_C,  0, 32'h3333_3330, 0, PC_A,  1, 0, 32'h0040_0300);
    vecs[13] = mk(1, PC_B,  1, 32'h0041_0100, 0, PC_C,  0, 0, 32'h0);
    vecs[14] = mk(0, 32'h0, 0, 32'h0,         0, PC_A,  0, 0, 32'h0);
    vecs[15] = mk(0, 32'h0, 0, 32'h0,         0, PC_B,  1, 1, 32'h0041_0100);
    vecs[16] = mk(0, 32'h0, 0, 32'h0,         0, PC_B3, 1, 1, 32'h0041_0100);

    reset = 1'b0;
    idle_inputs();
    i_pc = PC_A;
    repeat (3) tick();
    lookup_chk("reset", PC_A, 0, 0, 32'h0);
    chk("reset busy", {31'b0, o_busy}, 32'h0);
    chk("reset mpcnt", {16'b0, o_mispredict_cnt}, 32'h0);
    reset = 1'b1;
    tick();

    mp_model = 0;
    for (int i = 0; i < 17; i++) begin
      i_update_valid = vecs[i].up_v; i_update_pc = vecs[i].up_pc;
      i_update_taken = vecs[i].up_tk; i_update_target = vecs[i].up_tgt;
      i_update_mispredict = vecs[i].up_mp; i_pc = vecs[i].lk_pc;
      #1;
      chk($sformatf("vec%0d hit", i), {31'b0, o_hit}, {31'b0, vecs[i].e_hit});
      chk($sformatf("vec%0d pred", i), {31'b0, o_predict_taken}, {31'b0, vecs[i].e_pt});
      chk($sformatf("vec%0d tgt", i), o_target, vecs[i].e_tgt);
      if (vecs[i].up_v && vecs[i].up_mp) mp_model++;
      tick();
    end
    idle_inputs();
    chk("vec mpcnt", {16'b0, o_mispredict_cnt}, mp_model);

    sweep(0, 1'b1, busy_cycles, leaks);
    chk("sweep busy cycles", busy_cycles, 64);
    chk("sweep leaks", leaks, 0);
    lookup_chk("after sweep B", PC_B, 0, 0, 32'h0);
    lookup_chk("after sweep C", PC_C, 0, 0, 32'h0);
    do_update(PC_A, 1'b1, 32'h0040_0100);
    lookup_chk("realloc A", PC_A, 1, 1, 32'h0040_0100);

    sweep(10, 1'b0, busy_cycles, leaks);
    chk("restart busy cycles", busy_cycles, 74);
    chk("restart leaks", leaks, 0);
    lookup_chk("after restart A", PC_A, 0, 0, 32'h0);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    do_update(PC_D, 1'b1, 32'h0040_0D00);
    lookup_chk("alloc D", PC_D, 1, 1, 32'h0040_0D00);
    i_update_valid = 1'b1; i_update_pc = PC_C; i_update_taken = 1'b0; i_update_mispredict = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("mpcnt near sat", {16'b0, o_mispredict_cnt}, 32'h0000_FFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("mpcnt sat", {16'b0, o_mispredict_cnt}, 32'h0000_FFFF);
    idle_inputs();

    i_invalidate = 1'b1;
    tick();
    i_invalidate = 1'b0;
    repeat (5) tick();
    chk("mid sweep busy", {31'b0, o_busy}, 32'h1);
    reset = 1'b0;
    #1;
    chk("async reset busy", {31'b0, o_busy}, 32'h0);
    chk("async reset mpcnt", {16'b0, o_mispredict_cnt}, 32'h0);
    tick();
    reset = 1'b1;
    lookup_chk("post reset D", PC_D, 0, 0, 32'h0);
    tick();
    do_update(PC_C, 1'b1, 32'h0040_0C00);
    lookup_chk("post reset alloc C", PC_C, 1, 1, 32'h0040_0C00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
